// File: rtl/range_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// range_sweep_ctrl_pkg
// Shared parameters and types for the range-membership sweep controller.
//   DATA_WIDTH              : width of values and range bounds (unsigned)
//   RANGES_COUNT            : number of ranges swept for every value
//   VALUES_COUNT            : number of values checked per pass
//   COUNTER_WIDTH           : width of the saturating result counter
//   RANGE_MEM_ADDRESS_WIDTH : range ROM address width
//   VALUE_MEM_ADDRESS_WIDTH : value ROM address width
//   SWEEP_CYCLES_PER_VALUE  : cycles spent on one value (fetch + sweep + drain + accum)
//   sweep_state_t           : controller state encoding
// -----------------------------------------------------------------------------
package range_sweep_ctrl_pkg;

   localparam int DATA_WIDTH              = 49;
   localparam int RANGES_COUNT            = 190;
   localparam int VALUES_COUNT            = 1000;
   localparam int COUNTER_WIDTH           = 10;
   localparam int RANGE_MEM_ADDRESS_WIDTH = 8;
   localparam int VALUE_MEM_ADDRESS_WIDTH = 10;

   localparam int SWEEP_CYCLES_PER_VALUE  = RANGES_COUNT + 3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_VAL,
      SWEEP,
      DRAIN,
      ACCUM,
      DONE
   } sweep_state_t;

endpackage

// File: rtl/range_sweep_ctrl_in_range_cmp.sv
// -----------------------------------------------------------------------------
// in_range_cmp
// Combinational inclusive bounds check: hit_o = (lo_i <= value_i <= hi_i),
// unsigned. A range with lo_i > hi_i can never satisfy both halves, so
// inverted ranges naturally report no hit.
//   value_i : value under test
//   lo_i    : lower bound (inclusive)
//   hi_i    : upper bound (inclusive)
//   hit_o   : value lies inside [lo_i, hi_i]
// -----------------------------------------------------------------------------
module in_range_cmp #(
   parameter int DATA_WIDTH = range_sweep_ctrl_pkg::DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] value_i,
   input  logic [DATA_WIDTH-1:0] lo_i,
   input  logic [DATA_WIDTH-1:0] hi_i,
   output logic                  hit_o
);

   import range_sweep_ctrl_pkg::*;

   // Both comparisons are unsigned and inclusive at the ends, so a single
   // point range [x,x] matches exactly x.
   always_comb begin
      hit_o = (lo_i <= value_i) && (value_i <= hi_i);
   end

endmodule

// File: rtl/range_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// range_sweep_ctrl
// Walks every value in the value ROM and, for each one, streams every range
// from the range ROM through an inclusive comparator. Counts the values that
// fall inside at least one range and reports the count with a done pulse.
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   start_i       : begin a full pass (only looked at in IDLE)
//   busy_o        : pass in progress, including the DONE cycle
//   done_o        : one-cycle pulse, count_o final
//   count_o       : saturating count of values inside any range
//   value_rd_en_o : value ROM read strobe
//   value_addr_o  : value ROM address
//   value_data_i  : value ROM data, one cycle after the strobe
//   range_rd_en_o : range ROM read strobe
//   range_addr_o  : range ROM address
//   range_lo_i    : range lower bound, one cycle after the strobe
//   range_hi_i    : range upper bound, one cycle after the strobe
// -----------------------------------------------------------------------------
module range_sweep_ctrl #(
   parameter int DATA_WIDTH              = range_sweep_ctrl_pkg::DATA_WIDTH,
   parameter int RANGES_COUNT            = range_sweep_ctrl_pkg::RANGES_COUNT,
   parameter int VALUES_COUNT            = range_sweep_ctrl_pkg::VALUES_COUNT,
   parameter int COUNTER_WIDTH           = range_sweep_ctrl_pkg::COUNTER_WIDTH,
   parameter int RANGE_MEM_ADDRESS_WIDTH = range_sweep_ctrl_pkg::RANGE_MEM_ADDRESS_WIDTH,
   parameter int VALUE_MEM_ADDRESS_WIDTH = range_sweep_ctrl_pkg::VALUE_MEM_ADDRESS_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic [COUNTER_WIDTH-1:0]           count_o,
   output logic                               value_rd_en_o,
   output logic [VALUE_MEM_ADDRESS_WIDTH-1:0] value_addr_o,
   input  logic [DATA_WIDTH-1:0]              value_data_i,
   output logic                               range_rd_en_o,
   output logic [RANGE_MEM_ADDRESS_WIDTH-1:0] range_addr_o,
   input  logic [DATA_WIDTH-1:0]              range_lo_i,
   input  logic [DATA_WIDTH-1:0]              range_hi_i
);

   import range_sweep_ctrl_pkg::*;

   localparam logic [RANGE_MEM_ADDRESS_WIDTH-1:0] R_LAST =
      RANGE_MEM_ADDRESS_WIDTH'(RANGES_COUNT - 1);
   localparam logic [VALUE_MEM_ADDRESS_WIDTH-1:0] V_LAST =
      VALUE_MEM_ADDRESS_WIDTH'(VALUES_COUNT - 1);

   sweep_state_t                       state_q, state_d;
   logic [VALUE_MEM_ADDRESS_WIDTH-1:0] v_q, v_d;
   logic [RANGE_MEM_ADDRESS_WIDTH-1:0] r_q, r_d;
   logic [DATA_WIDTH-1:0]              value_q, value_d;
   logic                               hit_any_q, hit_any_d;
   logic [COUNTER_WIDTH-1:0]           count_q, count_d;
   logic                               range_hit;

   // The compare always looks at the value held for the current sweep and
   // whatever bounds the range ROM returned this cycle; the FSM decides
   // whether that result is meaningful.
   in_range_cmp #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_cmp (
      .value_i(value_q),
      .lo_i   (range_lo_i),
      .hi_i   (range_hi_i),
      .hit_o  (range_hit)
   );

   // State register and datapath flops. Reset is synchronous, so a reset
   // in the middle of a pass simply lands everything back at the idle
   // values on the next edge and the partial count is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         v_q       <= '0;
         r_q       <= '0;
         value_q   <= '0;
         hit_any_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         v_q       <= v_d;
         r_q       <= r_d;
         value_q   <= value_d;
         hit_any_q <= hit_any_d;
         count_q   <= count_d;
      end
   end

   // Next-state and output logic. The ROMs have one cycle of read latency,
   // so the value requested in FETCH_VAL arrives in the first SWEEP cycle,
   // and each range requested in SWEEP arrives one cycle later. That is
   // why the first SWEEP cycle only captures the value and DRAIN exists to
   // compare the final range after the strobes have stopped. Every range
   // is always swept, keeping the pass length fixed regardless of data.
   always_comb begin
      state_d       = state_q;
      v_d           = v_q;
      r_d           = r_q;
      value_d       = value_q;
      hit_any_d     = hit_any_q;
      count_d       = count_q;
      busy_o        = (state_q != IDLE);
      done_o        = 1'b0;
      value_rd_en_o = 1'b0;
      value_addr_o  = '0;
      range_rd_en_o = 1'b0;
      range_addr_o  = '0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               count_d   = '0;
               v_d       = '0;
               r_d       = '0;
               hit_any_d = 1'b0;
               state_d   = FETCH_VAL;
            end
         end

         FETCH_VAL: begin
            value_rd_en_o = 1'b1;
            value_addr_o  = v_q;
            r_d           = '0;
            state_d       = SWEEP;
         end

         SWEEP: begin
            range_rd_en_o = 1'b1;
            range_addr_o  = r_q;
            if (r_q == '0) begin
               value_d = value_data_i;
            end else begin
               hit_any_d = hit_any_q | range_hit;
            end
            if (r_q == R_LAST) begin
               r_d     = '0;
               state_d = DRAIN;
            end else begin
               r_d = r_q + RANGE_MEM_ADDRESS_WIDTH'(1);
            end
         end

         DRAIN: begin
            hit_any_d = hit_any_q | range_hit;
            state_d   = ACCUM;
         end

         ACCUM: begin
            if (hit_any_q && (count_q != '1)) begin
               count_d = count_q + COUNTER_WIDTH'(1);
            end
            hit_any_d = 1'b0;
            if (v_q == V_LAST) begin
               state_d = DONE;
            end else begin
               v_d     = v_q + VALUE_MEM_ADDRESS_WIDTH'(1);
               state_d = FETCH_VAL;
            end
         end

         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign count_o = count_q;

endmodule
